hall_emulator: RTL and testbench

Synthetic Hall-sensor source for the FOC datapath: integrates a signed per-cycle angle step into an electrical angle, then encodes that angle into the 4-bit Hall sector code consumed by the sector/angle-clamp stage. It also produces a one-cycle sector-edge strobe, a direction flag and a cycles-per-sector period measurement. It is used for open-loop bring-up and for closed-loop verification of the Hall decode path without a motor.

---
 rtl/hall_emulator_if.sv | 27 ++
 rtl/hall_emulator.sv | 132 +++++++++++++
 tb/tb_hall_emulator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hall_emulator_if.sv
// Bus between the Hall emulator and its driver.
//   en, step, load, load_angle : angle control from the master
//   angle_o, hall_o            : current electrical angle and its Hall code
//   edge_o, dir_o              : sector-change strobe and direction at last edge
//   period_o, period_vld       : cycles between the last two edges, and its valid flag
interface hall_emulator_if;
  logic               en;
  logic signed [31:0] step;
  logic               load;
  logic        [31:0] load_angle;
  logic        [31:0] angle_o;
  logic        [3:0]  hall_o;
  logic               edge_o;
  logic               dir_o;
  logic        [31:0] period_o;
  logic               period_vld;

  modport master (
    output en, step, load, load_angle,
    input  angle_o, hall_o, edge_o, dir_o, period_o, period_vld
  );

  modport slave (
    input  en, step, load, load_angle,
    output angle_o, hall_o, edge_o, dir_o, period_o, period_vld
  );
endinterface

// File: rtl/hall_emulator.sv
// Synthetic Hall-sensor source. Integrates a clamped signed step into an
// electrical angle, encodes the angle into a 4-bit Hall sector code, and
// reports sector edges, direction and the cycles-per-sector period.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : hall_emulator_if.slave (step/load controls in, angle/Hall status out)
module hall_emulator #(
  parameter logic [31:0] ANGLE_FULL = 32'd3600000,
  parameter logic [31:0] STEP_MAX   = 32'd599999
) (
  input  logic              clk,
  input  logic              rst_n,
  hall_emulator_if.slave    bus
);

  localparam logic signed [31:0] STEP_MAX_S = signed'(STEP_MAX);
  localparam logic signed [32:0] FULL_S     = signed'({1'b0, ANGLE_FULL});
  localparam logic        [31:0] SECT_W     = ANGLE_FULL / 32'd6;
  localparam logic        [31:0] HALF_W     = SECT_W / 32'd2;

  function automatic logic signed [31:0] clamp_step(input logic signed [31:0] s);
    if (s > STEP_MAX_S)
      return STEP_MAX_S;
    else if (s < -STEP_MAX_S)
      return -STEP_MAX_S;
    else
      return s;
  endfunction

  // A single correction suffices because |step| is below one sector width.
  function automatic logic [31:0] wrap_angle(input logic signed [32:0] a);
    logic signed [32:0] r;
    if (a < 0)
      r = a + FULL_S;
    else if (a >= FULL_S)
      r = a - FULL_S;
    else
      r = a;
    return r[31:0];
  endfunction

  // Sector boundaries sit half a sector off zero, so code 4 straddles the wrap.
  function automatic logic [3:0] hall_code(input logic [31:0] ang);
    if (ang < HALF_W)                          return 4'h4;
    else if (ang < HALF_W + SECT_W)            return 4'h5;
    else if (ang < HALF_W + 32'd2 * SECT_W)    return 4'h1;
    else if (ang < HALF_W + 32'd3 * SECT_W)    return 4'h3;
    else if (ang < HALF_W + 32'd4 * SECT_W)    return 4'h2;
    else if (ang < HALF_W + 32'd5 * SECT_W)    return 4'h6;
    else                                       return 4'h4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // ---- p0: clamp, integrate, wrap and encode the candidate angle ----
  logic signed [31:0] step_c_p0;
  logic signed [32:0] sum_p0;
  logic        [31:0] step_angle_p0;
  logic        [31:0] load_angle_p0;
  logic        [3:0]  step_hall_p0;
  logic        [3:0]  load_hall_p0;

  logic        [31:0] angle_p1;
  logic        [3:0]  hall_p1;
  logic               edge_p1;
  logic               dir_p1;
  logic        [31:0] period_p1;
  logic               period_vld_p1;
  logic        [31:0] cnt_p1;
  logic               armed_p1;

  always_comb begin
    step_c_p0     = clamp_step(bus.step);
    sum_p0        = signed'({1'b0, angle_p1}) + signed'({step_c_p0[31], step_c_p0});
    step_angle_p0 = wrap_angle(sum_p0);
    step_hall_p0  = hall_code(step_angle_p0);
    load_angle_p0 = (bus.load_angle < ANGLE_FULL) ? bus.load_angle : 32'd0;
    load_hall_p0  = hall_code(load_angle_p0);
  end

  // ---- p1: angle/Hall registers, edge detect and period measurement ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_p1      <= 32'd0;
      hall_p1       <= 4'h4;
      edge_p1       <= 1'b0;
      dir_p1        <= 1'b0;
      period_p1     <= 32'd0;
      period_vld_p1 <= 1'b0;
      cnt_p1        <= 32'd0;
      armed_p1      <= 1'b0;
    end else if (bus.load) begin
      angle_p1      <= load_angle_p0;
      hall_p1       <= load_hall_p0;
      edge_p1       <= 1'b0;
      cnt_p1        <= 32'd0;
      armed_p1      <= 1'b0;
      period_vld_p1 <= 1'b0;
    end else if (bus.en) begin
      angle_p1 <= step_angle_p0;
      hall_p1  <= step_hall_p0;
      if (step_hall_p0 != hall_p1) begin
        edge_p1  <= 1'b1;
        dir_p1   <= step_c_p0[31];
        cnt_p1   <= 32'd0;
        armed_p1 <= 1'b1;
        // The first edge after reset/load only starts the interval.
        if (armed_p1) begin
          period_p1     <= sat_inc(cnt_p1);
          period_vld_p1 <= 1'b1;
        end
      end else begin
        edge_p1 <= 1'b0;
        cnt_p1  <= sat_inc(cnt_p1);
      end
    end else begin
      edge_p1 <= 1'b0;
      cnt_p1  <= sat_inc(cnt_p1);
    end
  end

  assign bus.angle_o    = angle_p1;
  assign bus.hall_o     = hall_p1;
  assign bus.edge_o     = edge_p1;
  assign bus.dir_o      = dir_p1;
  assign bus.period_o   = period_p1;
  assign bus.period_vld = period_vld_p1;

endmodule

// File: tb/tb_hall_emulator.sv
// Self-checking bench for hall_emulator: directed scenarios plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_hall_emulator;

  localparam longint FULL  = 3600000;
  localparam longint SMAX  = 599999;
  localparam longint SECTW = 600000;

  logic clk;
  logic rst_n;
  hall_emulator_if hif ();

  hall_emulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // reference model state
  longint m_angle;
  longint m_period;
  longint m_last_edge;
  longint cyc;
  bit     m_edge;
  bit     m_dir;
  bit     m_pvld;
  bit     m_armed;
  int     codes [6] = '{4, 5, 1, 3, 2, 6};

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int sector_of(input longint a);
    return int'(((a + SECTW / 2) % FULL) / SECTW);
  endfunction

  function automatic longint clamp_of(input longint s);
    if (s > SMAX) return SMAX;
    if (s < -SMAX) return -SMAX;
    return s;
  endfunction

  task automatic model_reset();
    m_angle = 0; m_period = 0; m_last_edge = 0; m_edge = 0;
    m_dir = 0; m_pvld = 0; m_armed = 0;
  endtask

  task automatic model_step();
    longint s;
    longint la;
    int     old_sec;
    cyc++;
    s  = clamp_of(longint'(hif.step));
    la = longint'(hif.load_angle);
    if (hif.load) begin
      m_angle = (la < FULL) ? la : 0;
      m_edge = 0; m_armed = 0; m_pvld = 0;
    end else if (hif.en) begin
      old_sec = sector_of(m_angle);
      m_angle = ((m_angle + s) % FULL + FULL) % FULL;
      if (sector_of(m_angle) != old_sec) begin
        m_edge = 1;
        m_dir  = (s < 0);
        if (m_armed) begin
          m_period = cyc - m_last_edge;
          m_pvld   = 1;
        end
        m_armed     = 1;
        m_last_edge = cyc;
      end else begin
        m_edge = 0;
      end
    end else begin
      m_edge = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".angle"},  longint'(hif.angle_o), m_angle);
    check({tag, ".hall"},   longint'(hif.hall_o), longint'(codes[sector_of(m_angle)]));
    check({tag, ".edge"},   longint'(hif.edge_o), longint'(m_edge));
    check({tag, ".dir"},    longint'(hif.dir_o), longint'(m_dir));
    check({tag, ".period"}, longint'(hif.period_o), m_period);
    check({tag, ".pvld"},   longint'(hif.period_vld), longint'(m_pvld));
  endtask

  // One clock: model follows the inputs the DUT samples, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit en, input int step, input bit load, input int la);
    hif.en = en;
    hif.step = step;
    hif.load = load;
    hif.load_angle = la;
  endtask

  task automatic load_to(input int la);
    drive(0, 0, 1, la);
    tick("load");
    hif.load = 0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".angle"}, longint'(hif.angle_o), 0);
    check({tag, ".hall"},  longint'(hif.hall_o), 4);
    check({tag, ".edge"},  longint'(hif.edge_o), 0);
    check({tag, ".dir"},   longint'(hif.dir_o), 0);
    check({tag, ".period"}, longint'(hif.period_o), 0);
    check({tag, ".pvld"},  longint'(hif.period_vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    model_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // forward stepping
    drive(1, 100000, 0, 0);
    tick("fwd1");
    tick("fwd2");
    tick("fwd3");
    check("fwd3_angle", longint'(hif.angle_o), 300000);
    check("fwd3_hall",  longint'(hif.hall_o), 5);
    check("fwd3_edge",  longint'(hif.edge_o), 1);
    check("fwd3_dir",   longint'(hif.dir_o), 0);
    tick("fwd4");
    check("fwd4_edge",  longint'(hif.edge_o), 0);
    load_to(3500000);
    drive(1, 100000, 0, 0);
    tick("wrapf");
    check("wrapf_angle", longint'(hif.angle_o), 0);
    check("wrapf_hall",  longint'(hif.hall_o), 4);
    check("wrapf_edge",  longint'(hif.edge_o), 0);

    // reverse stepping
    load_to(0);
    drive(1, -100000, 0, 0);
    tick("rev1");
    check("rev1_angle", longint'(hif.angle_o), 3500000);
    tick("rev2");
    tick("rev3");
    check("rev3_angle", longint'(hif.angle_o), 3300000);
    check("rev3_edge",  longint'(hif.edge_o), 0);
    tick("rev4");
    check("rev4_hall", longint'(hif.hall_o), 6);
    check("rev4_edge", longint'(hif.edge_o), 1);
    check("rev4_dir",  longint'(hif.dir_o), 1);

    // period, continuous enable
    load_to(0);
    drive(1, 60000, 0, 0);
    for (int i = 0; i < 40; i++) tick("per");
    check("per_full", longint'(hif.period_o), 10);
    check("per_vld",  longint'(hif.period_vld), 1);

    // period, 50% enable duty
    load_to(0);
    for (int i = 0; i < 80; i++) begin
      drive(i % 2 == 0, 60000, 0, 0);
      tick("per50");
    end
    check("per50_full", longint'(hif.period_o), 20);

    // load mid-run, with en asserted too
    drive(1, 60000, 1, 1000000);
    tick("ld1");
    check("ld1_angle", longint'(hif.angle_o), 1000000);
    check("ld1_hall",  longint'(hif.hall_o), 1);
    check("ld1_edge",  longint'(hif.edge_o), 0);
    check("ld1_pvld",  longint'(hif.period_vld), 0);
    drive(1, 60000, 1, 4000000);
    tick("ld2");
    check("ld2_angle", longint'(hif.angle_o), 0);
    check("ld2_hall",  longint'(hif.hall_o), 4);

    // clamp
    drive(1, 700000, 0, 0);
    tick("clp1");
    check("clp1_angle", longint'(hif.angle_o), 599999);
    check("clp1_edge",  longint'(hif.edge_o), 1);
    tick("clp2");
    check("clp2_angle", longint'(hif.angle_o), 1199998);
    check("clp2_hall",  longint'(hif.hall_o), 1);
    for (int i = 0; i < 12; i++) tick("clp");
    drive(1, -700000, 0, 0);
    for (int i = 0; i < 12; i++) tick("clpn");

    // mid-run asynchronous reset
    async_reset("rst_mid");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int st;
      if ($urandom_range(0, 4) == 0) st = int'($urandom);
      else st = int'($urandom_range(0, 1400000)) - 700000;
      drive($urandom_range(0, 3) != 0, st, $urandom_range(0, 39) == 0,
            int'($urandom_range(0, 4000000)));
      tick("rnd");
      if (i == 1500) async_reset("rst_rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
